// File: rtl/onchip_mem_loader_pkg.sv
// Shared types and constants for the on-chip program memory boot loader.
package onchip_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } loader_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;

    localparam int CSUM_W = 32;

    // Zero every byte lane whose enable bit is clear.
    function automatic logic [31:0] mask_lanes(input logic [31:0] word, input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? word[8*i +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word with a lane mask.
// word/mask/complete already include the byte being accepted this cycle.
module loader_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic [31:0] word,
    output logic [3:0]  mask,
    output logic        complete,
    output logic        last
);

    logic [1:0]  lane_idx_r;
    logic [31:0] bytes_r;
    logic [3:0]  mask_r;

    // Merge the incoming byte into the stored lanes.
    always_comb begin
        word     = bytes_r;
        mask     = mask_r;
        complete = 1'b0;
        last     = 1'b0;
        if (byte_valid) begin
            word[{lane_idx_r, 3'b000} +: 8] = byte_data;
            mask     = mask_r | (4'b0001 << lane_idx_r);
            complete = (lane_idx_r == 2'd3) || byte_last;
            last     = byte_last;
        end else begin
            complete = 1'b0;
            last     = 1'b0;
        end
    end

    // Lane state; cleared lanes read back as zero in a partial word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_idx_r <= 2'd0;
            bytes_r    <= 32'h0000_0000;
            mask_r     <= 4'b0000;
        end else if (byte_valid) begin
            lane_idx_r <= lane_idx_r + 2'd1;
            bytes_r    <= word;
            mask_r     <= mask;
        end
    end

endmodule

// File: rtl/onchip_mem_loader.sv
// Streaming boot loader: packs bytes into words, writes them to program memory,
// then reads the image back and compares additive checksums.
module onchip_mem_loader
    import onchip_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 6500,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] words_written
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1'b1);

    loader_state_t       state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [3:0]          be_r;
    logic [31:0]         wdata_r;
    logic                cs_r;
    logic                we_r;
    logic                clken_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic [1:0]          err_code_r;
    logic [ADDR_W-1:0]   words_r;
    logic [ADDR_W-1:0]   ver_cnt_r;
    logic [CSUM_W-1:0]   wr_csum_r;
    logic [CSUM_W-1:0]   rd_csum_r;
    logic [3:0]          final_mask_r;
    logic                last_seen_r;

    logic                s_ready_s;
    logic                start_acc_s;
    logic                pk_clear_s;
    logic [31:0]         pk_word_s;
    logic [3:0]          pk_mask_s;
    logic                pk_complete_s;
    logic                pk_last_s;
    logic [CSUM_W-1:0]   rd_sum_s;

    // Handshake and start qualification decoded from the current state.
    always_comb begin
        s_ready_s   = (state_r == ST_FILL);
        start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                (state_r == ST_ERROR));
        pk_clear_s  = start_acc_s || (state_r == ST_WRITE);
        if (ver_cnt_r == words_r) begin
            rd_sum_s = rd_csum_r + mask_lanes(mem_readdata, final_mask_r);
        end else begin
            rd_sum_s = rd_csum_r + mask_lanes(mem_readdata, 4'b1111);
        end
    end

    loader_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear_s),
        .byte_data  (s_data),
        .byte_valid (s_valid && s_ready_s),
        .byte_last  (s_last),
        .word       (pk_word_s),
        .mask       (pk_mask_s),
        .complete   (pk_complete_s),
        .last       (pk_last_s)
    );

    // Loader FSM with registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            be_r         <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
            cs_r         <= 1'b0;
            we_r         <= 1'b0;
            clken_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            err_code_r   <= ERR_NONE;
            words_r      <= '0;
            ver_cnt_r    <= '0;
            wr_csum_r    <= '0;
            rd_csum_r    <= '0;
            final_mask_r <= 4'b0000;
            last_seen_r  <= 1'b0;
        end else begin
            clken_r <= 1'b1;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_acc_s) begin
                        state_r     <= ST_FILL;
                        addr_r      <= BASE_A;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        error_r     <= 1'b0;
                        err_code_r  <= ERR_NONE;
                        words_r     <= '0;
                        ver_cnt_r   <= '0;
                        wr_csum_r   <= '0;
                        rd_csum_r   <= '0;
                        last_seen_r <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (pk_complete_s) begin
                        state_r     <= ST_WRITE;
                        cs_r        <= 1'b1;
                        we_r        <= 1'b1;
                        wdata_r     <= pk_word_s;
                        be_r        <= pk_mask_s;
                        last_seen_r <= pk_last_s;
                    end
                end
                ST_WRITE: begin
                    we_r      <= 1'b0;
                    wr_csum_r <= wr_csum_r + mask_lanes(wdata_r, be_r);
                    words_r   <= words_r + ONE_A;
                    if (last_seen_r) begin
                        // Chip select stays up: the first verify read follows directly.
                        state_r      <= ST_VERIFY;
                        addr_r       <= BASE_A;
                        final_mask_r <= be_r;
                        be_r         <= 4'b1111;
                        ver_cnt_r    <= '0;
                    end else if (addr_r == LAST_A) begin
                        state_r    <= ST_ERROR;
                        cs_r       <= 1'b0;
                        busy_r     <= 1'b0;
                        error_r    <= 1'b1;
                        err_code_r <= ERR_OVERFLOW;
                    end else begin
                        state_r <= ST_FILL;
                        cs_r    <= 1'b0;
                        addr_r  <= addr_r + ONE_A;
                    end
                end
                ST_VERIFY: begin
                    ver_cnt_r <= ver_cnt_r + ONE_A;
                    if (ver_cnt_r != '0) begin
                        rd_csum_r <= rd_sum_s;
                    end
                    if ((ver_cnt_r + ONE_A) < words_r) begin
                        addr_r <= addr_r + ONE_A;
                    end else begin
                        cs_r <= 1'b0;
                    end
                    if (ver_cnt_r == words_r) begin
                        busy_r <= 1'b0;
                        if (rd_sum_s == wr_csum_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r    <= ST_ERROR;
                            error_r    <= 1'b1;
                            err_code_r <= ERR_CHECKSUM;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_r    <= 1'b0;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready        = s_ready_s;
    assign mem_address    = addr_r;
    assign mem_byteenable = be_r;
    assign mem_chipselect = cs_r;
    assign mem_write      = we_r;
    assign mem_writedata  = wdata_r;
    assign mem_clken      = clken_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign err_code       = err_code_r;
    assign words_written  = words_r;

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Scoreboard bench: instance 0 uses base 0, instance 1 uses base 6498 for overflow.
module tb_onchip_mem_loader;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        start_v = '0;
    logic [1:0][7:0]   s_data_v = '0;
    logic [1:0]        s_valid_v = '0;
    logic [1:0]        s_last_v = '0;
    logic [1:0]        s_ready_v;
    logic [1:0][12:0]  addr_v;
    logic [1:0][3:0]   be_v;
    logic [1:0]        cs_v;
    logic [1:0]        we_v;
    logic [1:0][31:0]  wd_v;
    logic [1:0][31:0]  rd_v = '0;
    logic [1:0]        clken_v;
    logic [1:0]        busy_v;
    logic [1:0]        done_v;
    logic [1:0]        error_v;
    logic [1:0][1:0]   ec_v;
    logic [1:0][12:0]  ww_v;

    logic [31:0] mem [0:1][0:8191];
    logic        corrupt = 1'b0;

    typedef struct {
        int          d;
        logic [12:0] a;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        onchip_mem_loader #(
            .ADDR_W(13), .DEPTH(6500), .BASE_ADDR(g == 0 ? 0 : 6498)
        ) dut (
            .clk(clk), .reset(reset), .start(start_v[g]),
            .s_data(s_data_v[g]), .s_valid(s_valid_v[g]), .s_ready(s_ready_v[g]),
            .s_last(s_last_v[g]), .mem_address(addr_v[g]), .mem_byteenable(be_v[g]),
            .mem_chipselect(cs_v[g]), .mem_write(we_v[g]), .mem_writedata(wd_v[g]),
            .mem_readdata(rd_v[g]), .mem_clken(clken_v[g]), .busy(busy_v[g]),
            .done(done_v[g]), .error(error_v[g]), .err_code(ec_v[g]),
            .words_written(ww_v[g])
        );
    end

    // Memory model: byte-lane writes, one-cycle registered reads, optional corruption of word 0.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cs_v[d]) begin
                if (we_v[d]) begin
                    for (int i = 0; i < 4; i++)
                        if (be_v[d][i]) mem[d][addr_v[d]][8*i +: 8] <= wd_v[d][8*i +: 8];
                end else if (d == 0 && corrupt && addr_v[d] == 13'd0) begin
                    rd_v[d] <= mem[d][addr_v[d]] ^ 32'h0000_0001;
                end else begin
                    rd_v[d] <= mem[d][addr_v[d]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe pops the scoreboard and is compared.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cs_v[d] && we_v[d]) begin
                chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                chk("wr_s_ready_low", 32'(s_ready_v[d]), 32'd0);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_dut", d, e.d);
                    chk("wr_addr", 32'(addr_v[d]), 32'(e.a));
                    chk("wr_be", 32'(be_v[d]), 32'(e.be));
                    chk("wr_data", wd_v[d], e.data);
                end
            end
        end
    end

    task automatic expect_wr(input int d, input logic [12:0] a, input logic [3:0] be,
                             input logic [31:0] data);
        wr_t e;
        e.d = d; e.a = a; e.be = be; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_s_ready", 32'(s_ready_v[d]), 32'd0);
        chk("rst_cs", 32'(cs_v[d]), 32'd0);
        chk("rst_we", 32'(we_v[d]), 32'd0);
        chk("rst_busy", 32'(busy_v[d]), 32'd0);
        chk("rst_done", 32'(done_v[d]), 32'd0);
        chk("rst_error", 32'(error_v[d]), 32'd0);
        chk("rst_err_code", 32'(ec_v[d]), 32'd0);
        chk("rst_addr", 32'(addr_v[d]), 32'd0);
        chk("rst_be", 32'(be_v[d]), 32'd0);
        chk("rst_wdata", wd_v[d], 32'd0);
        chk("rst_words", 32'(ww_v[d]), 32'd0);
        chk("rst_clken", 32'(clken_v[d]), 32'd0);
    endtask

    task automatic do_start(input int d);
        @(negedge clk); start_v[d] = 1'b1;
        @(negedge clk); start_v[d] = 1'b0;
        chk("busy_rise", 32'(busy_v[d]), 32'd1);
        chk("s_ready_rise", 32'(s_ready_v[d]), 32'd1);
    endtask

    task automatic push_byte(input int d, input logic [7:0] b, input logic last);
        int t = 0;
        s_data_v[d] = b; s_last_v[d] = last; s_valid_v[d] = 1'b1;
        while (!s_ready_v[d] && t < 20) begin
            @(negedge clk); t++;
        end
        if (t >= 20) chk("accept_timeout", t, 32'd0);
        @(negedge clk);
        s_valid_v[d] = 1'b0; s_last_v[d] = 1'b0;
    endtask

    task automatic wait_end(input int d);
        int t = 0;
        while (!(done_v[d] || error_v[d]) && t < 20000) begin
            @(negedge clk); t++;
        end
        chk("finish", 32'(done_v[d] || error_v[d]), 32'd1);
        chk("busy_fall", 32'(busy_v[d]), 32'd0);
    endtask

    task automatic chk_status(input int d, input logic dn, input logic er,
                              input logic [1:0] ec, input logic [12:0] ww);
        chk("done", 32'(done_v[d]), 32'(dn));
        chk("error", 32'(error_v[d]), 32'(er));
        chk("err_code", 32'(ec_v[d]), 32'(ec));
        chk("words_written", 32'(ww_v[d]), 32'(ww));
    endtask

    initial begin
        logic [7:0] pb [5];
        pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        reset = 1'b0;
        @(negedge clk);
        chk("clken_on", 32'(clken_v[0]), 32'd1);

        // 8 full bytes, two full words
        expect_wr(0, 13'd0, 4'hF, 32'h0403_0201);
        expect_wr(0, 13'd1, 4'hF, 32'h0807_0605);
        do_start(0);
        for (int i = 1; i <= 8; i++) push_byte(0, 8'(i), i == 8);
        wait_end(0);
        chk_status(0, 1'b1, 1'b0, 2'd0, 13'd2);

        // Partial final word: lanes 1..3 of word 1 keep stale data and must be masked
        expect_wr(0, 13'd0, 4'hF, 32'hDDCC_BBAA);
        expect_wr(0, 13'd1, 4'h1, 32'h0000_00EE);
        do_start(0);
        for (int i = 0; i < 5; i++) push_byte(0, pb[i], i == 4);
        wait_end(0);
        chk_status(0, 1'b1, 1'b0, 2'd0, 13'd2);

        // Back-pressure: s_valid idles every other cycle
        expect_wr(0, 13'd0, 4'hF, 32'h1312_1110);
        expect_wr(0, 13'd1, 4'h3, 32'h0000_1514);
        do_start(0);
        for (int i = 0; i < 6; i++) begin
            push_byte(0, 8'(8'h10 + i), i == 5);
            @(negedge clk);
        end
        wait_end(0);
        chk_status(0, 1'b1, 1'b0, 2'd0, 13'd2);

        // Verify mismatch via corrupted read of word 0
        corrupt = 1'b1;
        expect_wr(0, 13'd0, 4'hF, 32'h4433_2211);
        do_start(0);
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b0);
        push_byte(0, 8'h44, 1'b1);
        wait_end(0);
        chk_status(0, 1'b0, 1'b1, 2'd2, 13'd1);
        corrupt = 1'b0;

        // Overflow at the top of memory
        expect_wr(1, 13'd6498, 4'hF, 32'h0403_0201);
        expect_wr(1, 13'd6499, 4'hF, 32'h0807_0605);
        do_start(1);
        for (int i = 1; i <= 8; i++) push_byte(1, 8'(i), 1'b0);
        s_data_v[1] = 8'h09; s_valid_v[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk_status(1, 1'b0, 1'b1, 2'd1, 13'd2);
        chk("ovf_s_ready", 32'(s_ready_v[1]), 32'd0);
        chk("ovf_busy", 32'(busy_v[1]), 32'd0);
        s_valid_v[1] = 1'b0;

        // Reset in the middle of FILL, then a clean restart
        do_start(0);
        push_byte(0, 8'h55, 1'b0);
        push_byte(0, 8'h66, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset(0);
        reset = 1'b0;
        expect_wr(0, 13'd0, 4'hF, 32'hD4C3_B2A1);
        do_start(0);
        push_byte(0, 8'hA1, 1'b0);
        push_byte(0, 8'hB2, 1'b0);
        push_byte(0, 8'hC3, 1'b0);
        push_byte(0, 8'hD4, 1'b1);
        wait_end(0);
        chk_status(0, 1'b1, 1'b0, 2'd0, 13'd1);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/onchip_mem_loader.md
# onchip_mem_loader

Streaming boot loader sitting directly upstream of the 6500×32 single-port on-chip program memory. It accepts a byte stream, packs bytes little-endian into 32-bit words and writes them sequentially from a base word address, using byteenable for a partial final word. It then reads the whole image back, compares an additive checksum of the written image against the read-back image, and reports done or error. It owns the memory port exclusively while busy.

## Interface
- `ADDR_W`, 13: memory word-address width.
- `DEPTH`, 6500: memory depth in words; the highest legal address is `DEPTH-1`.
- `BASE_ADDR`, 0: first word address written.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a load. Ignored while `busy`.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data`/`s_last` valid.
- `s_ready` out 1: loader accepts the byte this cycle.
- `s_last` in 1: marks the final byte of the image.
- `mem_address` out ADDR_W: word address.
- `mem_byteenable` out 4: lane enables; bit i covers bits [8i+7:8i].
- `mem_chipselect` out 1: memory access strobe.
- `mem_write` out 1: write strobe; only valid when `mem_chipselect` is high.
- `mem_writedata` out 32: packed word.
- `mem_readdata` in 32: memory read data, valid one cycle after address.
- `mem_clken` out 1: memory clock enable, tied to 1 outside reset.
- `busy` out 1: high from the cycle after an accepted `start` until DONE or ERROR.
- `done` out 1: sticky success flag, cleared by the next accepted `start`.
- `error` out 1: sticky failure flag, cleared by the next accepted `start`.
- `err_code` out 2: 0=none, 1=overflow, 2=checksum mismatch.
- `words_written` out ADDR_W: number of words written in the current or last load.

## Operation
- States: IDLE, FILL, WRITE, VERIFY, DONE, ERROR.
- **IDLE/DONE/ERROR:** an accepted `start` does the following, then moves to FILL:
  - clears `done`, `error`, `err_code`, `words_written`, both checksums and the lane index;
  - loads the address counter with `BASE_ADDR`.
- **FILL:**
  - `s_ready`=1. On `s_valid & s_ready`, the byte goes to lane `lane_idx` (first byte → bits 7:0) and the lane bit is set.
  - When `lane_idx`==3 or `s_last`, move to WRITE and latch `last_seen`.
- **WRITE:** one cycle with `s_ready`=0 and `mem_chipselect`=`mem_write`=1.
  - `mem_byteenable` = the filled-lane mask (4'b1111 except possibly the final word).
  - Add the word to the write checksum, with unfilled lanes masked to 0.
  - Increment the address and `words_written`, and clear the lane state.
  - Next state:
    - if `last_seen` → VERIFY, with the address reset to `BASE_ADDR`;
    - else if the address just written was `DEPTH-1` → ERROR, `err_code`=1 (no further bytes accepted, no wrap);
    - else → FILL.
- **VERIFY:** pipelined reads with `mem_chipselect`=1 and `mem_write`=0.
  - Cycle k drives address `BASE_ADDR+k`; cycle k+1 adds `mem_readdata` to the read checksum.
  - The final word is masked with the stored final lane mask.
  - The stage lasts `words_written`+1 cycles. After the last capture, go to DONE if the checksums are equal, else to ERROR with `err_code`=2.
- **Checksums:** 32-bit, modulo 2^32 addition.
- **Stream inputs:** `s_valid` with `s_ready`=0 is not consumed; `s_data` is ignored outside FILL.

## Timing
- **Reset values:**
  - `s_ready`, `mem_chipselect`, `mem_write`, `busy`, `done`, `error` = 0;
  - `mem_clken` = 0;
  - `err_code`, `mem_address`, `mem_byteenable`, `mem_writedata`, `words_written` = 0;
  - state = IDLE.
- All outputs are registered except `s_ready`, which is decoded from state.
- `start` at cycle t → `busy` and `s_ready` high at t+1.
- **Throughput:** 4 bytes per 5 cycles maximum; each word needs 4 FILL cycles plus 1 WRITE cycle.
- A write takes effect in its WRITE cycle; the memory has no wait states.
- **Verify latency:** `words_written`+1 cycles. `done`/`error` rise 1 cycle after the final capture, and `busy` falls in the same cycle.
- If `reset` is asserted mid-operation, all outputs return to reset values on the next edge. Partially written memory is left as-is.
- A `start` that coincides with `reset` is ignored.

## Structure
- Package `onchip_mem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - the `err_code` localparams `ERR_NONE`/`ERR_OVERFLOW`/`ERR_CHECKSUM`;
  - the checksum width constant.
- Sub-module `loader_word_packer` holds the lane index, byte registers, lane mask and word-complete/last flags. It has inputs byte/valid/last/clear, and outputs word/mask/complete.
- The FSM, address counter and checksums live in the top level.

## Test plan
- **8-byte stream:** bytes 01..08, `s_last` on byte 8, `BASE_ADDR`=0 →
  - writes 0x04030201 @0 and 0x08070605 @1, both with byteenable 1111;
  - `words_written`=2, `done`=1, `err_code`=0.
- **Partial final word:** 5-byte stream AA BB CC DD EE →
  - second write is data 0x000000EE, byteenable 0001, address 1;
  - verify passes.
- **Stream back-pressure:** `s_valid` toggles every cycle during FILL →
  - `s_ready` is low in every WRITE cycle;
  - no byte is lost or duplicated; the checksum matches.
- **Overflow:** `BASE_ADDR`=6498, 12 bytes with no `s_last` →
  - words written at 6498 and 6499;
  - `error`=1, `err_code`=1, `s_ready`=0 afterwards.
- **Verify mismatch:** the bench model corrupts the read of word 0 →
  - `error`=1, `err_code`=2, `done`=0.
- **Reset and restart:** `reset` asserted in the middle of FILL →
  - next cycle all outputs are at reset values;
  - a new `start` with 4 bytes completes with `done`=1 and `words_written`=1.
